// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 8-bit core.
// Walks FETCH/DECODE/EXEC/MEM/WB per instruction, handshakes with instruction and
// data memory, aborts stalled accesses after TIMEOUT cycles and owns the ALUOp code.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode halts the core; otherwise NOP).
module main_control_fsm #(
  parameter int OPCODE_W  = 4,
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                alu_zero,
  input  logic                alu_lt,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_branch,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic [1:0]          ALUOp,
  output logic                bus_err,
  output logic                halted
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LWI  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ABORT
  } state_t;

  state_t                state, next_state;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  timeout;

  // registered outputs and their next values
  logic imem_req_q, dmem_req_q, mem_read_q, mem_write_q, reg_write_q, reg_dst_q;
  logic alu_src_q, mem_to_reg_q, bus_err_q, halted_q, jmp_q, beq_q, bne_q, blt_q;
  logic [1:0] aluop_q;
  logic imem_req_d, dmem_req_d, mem_read_d, mem_write_d, reg_write_d, reg_dst_d;
  logic alu_src_d, mem_to_reg_d, bus_err_d, halted_d, jmp_d, beq_d, bne_d, blt_d;
  logic [1:0] aluop_d;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction

  assign timeout = (wait_cnt == CNT_LAST);

  // State, latched opcode, wait counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      opcode_q     <= '0;
      wait_cnt     <= '0;
      imem_req_q   <= 1'b1;  // masked by rst_n below; lets the fetch start right at release
      dmem_req_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      aluop_q      <= 2'b00;
      bus_err_q    <= 1'b0;
      halted_q     <= 1'b0;
      jmp_q        <= 1'b0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      blt_q        <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && imem_ack) opcode_q <= opcode;
      if ((next_state == S_FETCH || next_state == S_MEM) && next_state != state)
        wait_cnt <= '0;
      else if (((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack)) && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      aluop_q      <= aluop_d;
      bus_err_q    <= bus_err_d;
      halted_q     <= halted_d;
      jmp_q        <= jmp_d;
      beq_q        <= beq_d;
      bne_q        <= bne_d;
      blt_q        <= blt_d;
    end
  end

  // Next-state selection; an ack on the last wait cycle wins over the timeout
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (imem_ack) next_state = S_DECODE;
                else if (timeout) next_state = S_ABORT;
      S_DECODE: begin
        if (opcode_q == OP_HALT) next_state = S_HALT;
        else if (is_legal(opcode_q)) next_state = S_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          next_state = S_HALT;
`else
          next_state = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R, OP_ADDI, OP_LWI, OP_SUBI: next_state = S_WB;
          OP_LW, OP_SW:                   next_state = S_MEM;
          default:                        next_state = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_ack) next_state = (opcode_q == OP_LW) ? S_WB : S_FETCH;
                else if (timeout) next_state = S_ABORT;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      S_ABORT:  next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decode from the state being entered, so registered outputs line up with it
  always_comb begin
    imem_req_d = 1'b0; dmem_req_d = 1'b0; mem_read_d = 1'b0; mem_write_d = 1'b0;
    reg_write_d = 1'b0; reg_dst_d = 1'b0; alu_src_d = 1'b0; mem_to_reg_d = 1'b0;
    aluop_d = 2'b00; bus_err_d = 1'b0; halted_d = 1'b0;
    jmp_d = 1'b0; beq_d = 1'b0; bne_d = 1'b0; blt_d = 1'b0;
    case (next_state)
      S_FETCH: imem_req_d = 1'b1;
      S_EXEC: begin
        case (opcode_q)
          OP_R:                         aluop_d = 2'b10;
          OP_LW, OP_SW, OP_ADDI, OP_LWI: alu_src_d = 1'b1;
          OP_SUBI: begin aluop_d = 2'b01; alu_src_d = 1'b1; end
          OP_BEQ:  begin aluop_d = 2'b01; beq_d = 1'b1; end
          OP_BNE:  begin aluop_d = 2'b01; bne_d = 1'b1; end
          OP_BLT:  begin aluop_d = 2'b11; blt_d = 1'b1; end
          OP_J:    jmp_d = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req_d  = 1'b1;
        mem_read_d  = (opcode_q == OP_LW);
        mem_write_d = (opcode_q == OP_SW);
      end
      S_WB: begin
        reg_write_d  = 1'b1;
        reg_dst_d    = (opcode_q == OP_R);
        mem_to_reg_d = (opcode_q == OP_LW);
      end
      S_HALT:  halted_d  = 1'b1;
      S_ABORT: bus_err_d = 1'b1;
      default: ;
    endcase
  end

  // Every output is forced low while rst_n is low, including the cycle reset is asserted.
  // IR/PC capture on fetch and the branch decision need the same-cycle ack / ALU flags.
  assign imem_req   = imem_req_q   & rst_n;
  assign dmem_req   = dmem_req_q   & rst_n;
  assign mem_read   = mem_read_q   & rst_n;
  assign mem_write  = mem_write_q  & rst_n;
  assign ir_write   = imem_req_q & imem_ack & rst_n;
  assign pc_write   = ((imem_req_q & imem_ack) | jmp_q) & rst_n;
  assign pc_branch  = ((beq_q & alu_zero) | (bne_q & ~alu_zero) | (blt_q & alu_lt)) & rst_n;
  assign reg_write  = reg_write_q  & rst_n;
  assign reg_dst    = reg_dst_q    & rst_n;
  assign alu_src    = alu_src_q    & rst_n;
  assign mem_to_reg = mem_to_reg_q & rst_n;
  assign ALUOp      = aluop_q & {2{rst_n}};
  assign bus_err    = bus_err_q    & rst_n;
  assign halted     = halted_q     & rst_n;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-cycle expected output vectors go into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0;
  logic       imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_branch;
  logic       reg_write, reg_dst, alu_src, mem_to_reg, bus_err, halted;
  logic [1:0] ALUOp;

  always #5 clk = ~clk;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .imem_req(imem_req), .dmem_req(dmem_req),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_branch(pc_branch), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .ALUOp(ALUOp), .bus_err(bus_err), .halted(halted)
  );

  // Output vector bit map
  localparam logic [14:0] IREQ = 15'h4000, DREQ = 15'h2000, MRD = 15'h1000, MWR = 15'h0800;
  localparam logic [14:0] IRW  = 15'h0400, PCW  = 15'h0200, PCB = 15'h0100, RW  = 15'h0080;
  localparam logic [14:0] RDST = 15'h0040, ASRC = 15'h0020, M2R = 15'h0010;
  localparam logic [14:0] AOP_SUB = 15'h0004, AOP_R = 15'h0008, AOP_SLT = 15'h000C;
  localparam logic [14:0] BERR = 15'h0002, HLT = 15'h0001;
  localparam logic [14:0] FACK = IREQ | IRW | PCW;

  wire [14:0] got = {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_branch,
                     reg_write, reg_dst, alu_src, mem_to_reg, ALUOp, bus_err, halted};

  typedef struct {
    logic [14:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: compare whatever the DUT presents this cycle against the queued expectation
  always @(negedge clk) begin
    exp_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      n_checks++;
      if (got === it.exp) n_pass++;
      else $display("FAIL %s: got %b required %b (t=%0t)", it.name, got, it.exp, $time);
    end
  end

  task automatic check(input logic ok, input string nm);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %b (t=%0t)", nm, got, $time);
  endtask

  // Drive one cycle of inputs and queue the outputs required for that cycle
  task automatic step(input logic r, input logic ia, input logic da, input logic z,
                      input logic lt, input logic [3:0] op, input logic [14:0] e,
                      input string nm);
    exp_t it;
    @(posedge clk); #1;
    rst_n = r; imem_ack = ia; dmem_ack = da; alu_zero = z; alu_lt = lt; opcode = op;
    it.exp = e; it.name = nm;
    sb.push_back(it);
  endtask

  // Idle cycles drive an illegal opcode to confirm it is only sampled on imem_ack
  task automatic idle(input logic [14:0] e, input string nm);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, e, nm);
  endtask

  task automatic fetch(input logic [3:0] op, input string nm);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op, FACK, nm);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 15'h0, "reset");
    @(negedge clk); #1;
    check(got === 15'h0, "reset_state");

    // R-type: ir_write @1, ALUOp=10 @3, reg_write+reg_dst @4
    fetch(4'h0, "r_fetch"); idle(15'h0, "r_decode"); idle(AOP_R, "r_exec");
    idle(RW | RDST, "r_wb");

    // LW with three data wait states
    fetch(4'h1, "lw_fetch"); idle(15'h0, "lw_decode"); idle(ASRC, "lw_exec");
    for (int i = 0; i < 3; i++) idle(DREQ | MRD, "lw_mem_wait");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, DREQ | MRD, "lw_mem_ack");
    idle(RW | M2R, "lw_wb");

    // SW, ADDI, SUBI, LWI
    fetch(4'h2, "sw_fetch"); idle(15'h0, "sw_decode"); idle(ASRC, "sw_exec");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, DREQ | MWR, "sw_mem_ack");
    fetch(4'h3, "addi_fetch"); idle(15'h0, "addi_decode"); idle(ASRC, "addi_exec");
    idle(RW, "addi_wb");
    fetch(4'h5, "subi_fetch"); idle(15'h0, "subi_decode"); idle(ASRC | AOP_SUB, "subi_exec");
    idle(RW, "subi_wb");
    fetch(4'h4, "lwi_fetch"); idle(15'h0, "lwi_decode"); idle(ASRC, "lwi_exec");
    idle(RW, "lwi_wb");

    // Branches and jump
    fetch(4'h6, "beq_fetch"); idle(15'h0, "beq_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, AOP_SUB | PCB, "beq_taken");
    fetch(4'h6, "beq2_fetch"); idle(15'h0, "beq2_decode");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, AOP_SUB, "beq_not_taken");
    fetch(4'h7, "bne_fetch"); idle(15'h0, "bne_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, AOP_SUB, "bne_not_taken");
    fetch(4'h8, "blt_fetch"); idle(15'h0, "blt_decode");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, AOP_SLT | PCB, "blt_taken");
    fetch(4'h9, "j_fetch"); idle(15'h0, "j_decode"); idle(PCW, "j_exec");

    // Fetch timeout after 16 request cycles, then an ack on the 16th cycle wins
    for (int i = 0; i < 16; i++) idle(IREQ, "fetch_wait");
    idle(BERR, "fetch_timeout");
    @(negedge clk); #1;
    check(bus_err === 1'b1 && imem_req === 1'b0, "expired_wait");
    for (int i = 0; i < 15; i++) idle(IREQ, "fetch_wait2");
    fetch(4'h3, "fetch_ack_last"); idle(15'h0, "late_decode"); idle(ASRC, "late_exec");
    idle(RW, "late_wb");

    // Data-side timeout during SW
    fetch(4'h2, "swto_fetch"); idle(15'h0, "swto_decode"); idle(ASRC, "swto_exec");
    for (int i = 0; i < 16; i++) idle(DREQ | MWR, "swto_mem_wait");
    idle(BERR, "mem_timeout");

    // Illegal opcode 0xC
    fetch(4'hC, "ill_fetch"); idle(15'h0, "ill_decode");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, HLT, "ill_halted");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 15'h0, "ill_reset");
`else
    idle(IREQ, "ill_nop_fetch");
`endif

    // HALT is sticky and ignores fetch acks until reset
    fetch(4'hF, "halt_fetch"); idle(15'h0, "halt_decode");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, HLT, "halted");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 15'h0, "halt_reset");

    // Reset during MEM of SW aborts the write; fetch resumes on release
    fetch(4'h2, "sw2_fetch"); idle(15'h0, "sw2_decode"); idle(ASRC, "sw2_exec");
    for (int i = 0; i < 2; i++) idle(DREQ | MWR, "sw2_mem_wait");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 15'h0, "sw2_reset_mid_mem");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 15'h0, "sw2_reset_hold");
    fetch(4'h0, "post_reset_fetch"); idle(15'h0, "post_reset_decode");
    idle(AOP_R, "post_reset_exec"); idle(RW | RDST, "post_reset_wb");
    idle(IREQ, "post_reset_next_fetch");

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
